// File: rtl/mprj_io_cfg_seq.sv
// ============================================================================
// mprj_io_cfg_seq
// ----------------------------------------------------------------------------
// Configuration sequencer for the user-project GPIO pad ring.
//
// A start request walks the selected pad areas in address order. For each pad
// one 5-bit configuration word {dm[2:0], inp_dis, oeb} is fetched over a
// req/ack port, and the word drives that pad's control bits into mprj_io.
// Area 1 is pads 0..AREA1PADS-1 and area 2 is pads AREA1PADS..TOTAL_PADS-1.
//
// Ports
//   clock       : single clock, rising edge
//   resetn      : asynchronous active-low reset
//   load_start  : start a sequence (sampled only in IDLE)
//   load_area   : bit0 = area 1, bit1 = area 2 (sampled with load_start)
//   busy        : sequence in progress (FETCH / APPLY)
//   done        : one-cycle pulse at the end of a sequence
//   cfg_req     : fetch request
//   cfg_addr    : pad index being fetched, stable while cfg_req = 1
//   cfg_ack     : fetch acknowledge, cfg_data valid in the same cycle
//   cfg_data    : {dm[2:0], inp_dis, oeb}
//   oeb         : per-pad output enable, active-low
//   inp_dis     : per-pad input disable
//   dm          : per-pad drive mode, pad n at [3n+2:3n]
//
// Build option
//   MPRJ_IO_CFG_SHADOW_EN : when defined, fetched words land in a shadow bank
//   and all selected pads update together on the edge entering FINISH, so the
//   pads never show a mixed old/new configuration. When undefined, each pad
//   updates on the edge where its ack is taken.
// ============================================================================
module mprj_io_cfg_seq #(
   parameter int AREA1PADS  = 19,   // MPRJ_IO_PADS_1
   parameter int TOTAL_PADS = 38,   // MPRJ_IO_PADS
   parameter int AW         = $clog2(TOTAL_PADS)
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    load_start,
   input  logic [1:0]              load_area,
   output logic                    busy,
   output logic                    done,
   output logic                    cfg_req,
   output logic [AW-1:0]           cfg_addr,
   input  logic                    cfg_ack,
   input  logic [4:0]              cfg_data,
   output logic [TOTAL_PADS-1:0]   oeb,
   output logic [TOTAL_PADS-1:0]   inp_dis,
   output logic [3*TOTAL_PADS-1:0] dm
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_APPLY,
      S_FINISH
   } state_t;

   localparam logic [AW-1:0] A1_FIRST = AW'(0);
   localparam logic [AW-1:0] A2_FIRST = AW'(AREA1PADS);
   localparam logic [AW-1:0] A1_LAST  = AW'(AREA1PADS - 1);
   localparam logic [AW-1:0] A2_LAST  = AW'(TOTAL_PADS - 1);

   // Pad reset state: input enabled, output driver off.
   localparam logic [3*TOTAL_PADS-1:0] DM_RESET_ALL = {TOTAL_PADS{3'b001}};

   state_t          r_state;
   logic            r_busy;
   logic            r_done;
   logic            r_req;
   logic [AW-1:0]   r_addr;
   logic [AW-1:0]   r_last;
   logic [1:0]      r_area;

   logic [TOTAL_PADS-1:0]   r_oeb;
   logic [TOTAL_PADS-1:0]   r_inp_dis;
   logic [3*TOTAL_PADS-1:0] r_dm;

   // A word is accepted only while fetching; stray acks elsewhere are ignored.
   logic w_take;
   // Last pad of the sequence is being applied; next edge enters FINISH.
   logic w_commit;

   assign w_take   = (r_state == S_FETCH) && cfg_ack;
   assign w_commit = (r_state == S_APPLY) && (r_addr == r_last);

   assign busy     = r_busy;
   assign done     = r_done;
   assign cfg_req  = r_req;
   assign cfg_addr = r_addr;
   assign oeb      = r_oeb;
   assign inp_dis  = r_inp_dis;
   assign dm       = r_dm;

   // -------------------------------------------------------------------------
   // Sequencer FSM with registered outputs
   // -------------------------------------------------------------------------
   // NOTE: all state and registered outputs use non-blocking assignments so
   // every decision in this block sees the values from before the edge.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_last  <= '0;
         r_area  <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (load_start) begin
                  if (load_area != 2'b00) begin
                     r_area  <= load_area;
                     r_addr  <= load_area[0] ? A1_FIRST : A2_FIRST;
                     r_last  <= load_area[1] ? A2_LAST  : A1_LAST;
                     r_req   <= 1'b1;
                     r_busy  <= 1'b1;
                     r_state <= S_FETCH;
                  end else begin
                     // Empty selection: report completion without fetching.
                     r_done  <= 1'b1;
                     r_state <= S_FINISH;
                  end
               end
            end

            S_FETCH: begin
               if (cfg_ack) begin
                  r_req   <= 1'b0;
                  r_state <= S_APPLY;
               end
            end

            S_APPLY: begin
               if (r_addr == r_last) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_FINISH;
               end else begin
                  // Both areas selected: AREA1PADS-1 simply rolls into AREA1PADS.
                  r_addr  <= r_addr + AW'(1);
                  r_req   <= 1'b1;
                  r_state <= S_FETCH;
               end
            end

            S_FINISH: begin
               // A start pulse here is deliberately dropped.
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

`ifdef MPRJ_IO_CFG_SHADOW_EN
   // -------------------------------------------------------------------------
   // Shadow bank: collects words during the sequence, copied out at the end.
   // -------------------------------------------------------------------------
   logic [TOTAL_PADS-1:0]   r_sh_oeb;
   logic [TOTAL_PADS-1:0]   r_sh_inp_dis;
   logic [3*TOTAL_PADS-1:0] r_sh_dm;

   // NOTE: the shadow bank is reset like the outputs so an interrupted
   // sequence cannot leave a partial configuration behind for the next commit.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_sh_oeb     <= '1;
         r_sh_inp_dis <= '0;
         r_sh_dm      <= DM_RESET_ALL;
      end else if (w_take) begin
         for (int p = 0; p < TOTAL_PADS; p++) begin
            if (AW'(p) == r_addr) begin
               r_sh_oeb[p]      <= cfg_data[0];
               r_sh_inp_dis[p]  <= cfg_data[1];
               r_sh_dm[3*p +: 3] <= cfg_data[4:2];
            end
         end
      end
   end

   // Only pads inside the latched area mask are copied; the rest keep state.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_oeb     <= '1;
         r_inp_dis <= '0;
         r_dm      <= DM_RESET_ALL;
      end else if (w_commit) begin
         for (int p = 0; p < TOTAL_PADS; p++) begin
            if ((p < AREA1PADS) ? r_area[0] : r_area[1]) begin
               r_oeb[p]       <= r_sh_oeb[p];
               r_inp_dis[p]   <= r_sh_inp_dis[p];
               r_dm[3*p +: 3] <= r_sh_dm[3*p +: 3];
            end
         end
      end
   end
`else
   // -------------------------------------------------------------------------
   // Direct update: each pad changes on the edge where its ack is taken.
   // -------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_oeb     <= '1;
         r_inp_dis <= '0;
         r_dm      <= DM_RESET_ALL;
      end else if (w_take) begin
         for (int p = 0; p < TOTAL_PADS; p++) begin
            if (AW'(p) == r_addr) begin
               r_oeb[p]       <= cfg_data[0];
               r_inp_dis[p]   <= cfg_data[1];
               r_dm[3*p +: 3] <= cfg_data[4:2];
            end
         end
      end
   end
`endif

endmodule
